// File: rtl/led_pattern_ctrl_if.sv
// rtl/led_pattern_ctrl_if.sv - received-byte strobe bundle between uart_rx and the LED engine
interface led_pattern_ctrl_if;
    logic       rx_valid;
    logic [7:0] rx_byte;

    modport master (output rx_valid, output rx_byte);
    modport slave  (input  rx_valid, input  rx_byte);
endinterface

// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - N-LED pattern engine (scan/direct/blink/rotate) with PWM dimming, fed by UART bytes
module led_pattern_ctrl #(
    parameter int N_LEDS    = 4,
    parameter int STEP_BITS = 23
) (
    input  logic              clk_50M,
    input  logic              rst,
    led_pattern_ctrl_if.slave rx,
    output logic [N_LEDS-1:0] leds,
    output logic [1:0]        mode
);
    localparam int POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LEDS - 1);

    localparam logic [1:0] MODE_SCAN   = 2'd0;
    localparam logic [1:0] MODE_DIRECT = 2'd1;
    localparam logic [1:0] MODE_BLINK  = 2'd2;
    localparam logic [1:0] MODE_ROTATE = 2'd3;

    typedef enum logic {IDLE, WAIT_DATA} state_t;
    state_t state, state_next;

    logic [N_LEDS-1:0]    pattern;
    logic [3:0]           bright;
    logic [3:0]           pwm_cnt;
    logic [POS_W-1:0]     pos;
    logic                 dir_down;
    logic                 blink_on;
    logic [STEP_BITS-1:0] prescaler;
    logic                 tick;
    logic [7:0]           b;
    logic                 cmd_direct, cmd_mode, cmd_bright, cmd_load;
    logic [N_LEDS-1:0]    scan_raw;
    logic [N_LEDS-1:0]    raw;
    logic                 pwm_en;
    logic                 unused_rx_bits;

    assign b              = rx.rx_byte;
    assign unused_rx_bits = ^b;
    assign tick           = &prescaler;
    assign pwm_en         = (bright == 4'd15) || (pwm_cnt < bright);

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_direct = 1'b0;
        cmd_mode   = 1'b0;
        cmd_bright = 1'b0;
        cmd_load   = 1'b0;
        if (rx.rx_valid) begin
            case (state)
                IDLE: begin
                    if (!b[7]) begin
                        cmd_direct = 1'b1;
                    end else begin
                        case (b[6:5])
                            2'b00:   cmd_mode   = 1'b1;
                            2'b01:   cmd_bright = 1'b1;
                            2'b10:   state_next = WAIT_DATA;
                            default: ;
                        endcase
                    end
                end
                WAIT_DATA: begin
                    // any byte value is data here, even one that looks like a command
                    cmd_load   = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        scan_raw = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            scan_raw[i] = (pos == POS_W'(N_LEDS - 1 - i));
        end
        raw = pattern;
        case (mode)
            MODE_SCAN:  raw = scan_raw;
            MODE_BLINK: raw = blink_on ? pattern : '0;
            default:    raw = pattern;
        endcase
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            leds      <= '0;
            mode      <= MODE_SCAN;
            pattern   <= '0;
            bright    <= 4'd15;
            pos       <= '0;
            dir_down  <= 1'b0;
            blink_on  <= 1'b1;
            prescaler <= '0;
            pwm_cnt   <= 4'd0;
        end else begin
            prescaler <= prescaler + 1'b1;
            pwm_cnt   <= pwm_cnt + 1'b1;
            leds      <= raw & {N_LEDS{pwm_en}};

            if (tick) begin
                case (mode)
                    MODE_SCAN: begin
                        if (!dir_down) begin
                            if (pos == POS_LAST) dir_down <= 1'b1;
                            else                 pos      <= pos + 1'b1;
                        end else begin
                            if (pos == '0) dir_down <= 1'b0;
                            else           pos      <= pos - 1'b1;
                        end
                    end
                    MODE_BLINK:  blink_on <= !blink_on;
                    MODE_ROTATE: pattern  <= (pattern << 1) | (pattern >> (N_LEDS - 1));
                    default: ;
                endcase
            end

            // command writes come last so they override a same-cycle tick
            if (cmd_direct) begin
                mode    <= MODE_DIRECT;
                pattern <= N_LEDS'(b[3:0]);
            end
            if (cmd_mode) begin
                mode     <= b[1:0];
                pos      <= '0;
                dir_down <= 1'b0;
                blink_on <= 1'b1;
            end
            if (cmd_bright) begin
                bright <= b[3:0];
            end
            if (cmd_load) begin
                mode    <= MODE_DIRECT;
                pattern <= b[N_LEDS-1:0];
            end
        end
    end
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - scoreboard bench for led_pattern_ctrl
module tb_led_pattern_ctrl;
    logic       clk_50M = 1'b0;
    logic       rst     = 1'b1;
    logic [3:0] leds0;
    logic [1:0] mode0;
    logic [0:0] leds1;
    logic [1:0] mode1;
    int         cyc   = 0;
    int         base  = 0;
    int         tests = 0;
    int         fails = 0;
    logic       flush = 1'b0;

    typedef struct {
        int          at;
        int          which;
        int          kind;
        logic [3:0]  val;
        logic [63:0] name;
    } exp_t;
    exp_t sb[$];

    int         scan_at [11] = '{1, 8, 9, 17, 25, 33, 41, 49, 57, 65, 73};
    logic [3:0] scan_v  [11] = '{4'b1000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
                                 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b0100};

    led_pattern_ctrl_if ifc0();
    led_pattern_ctrl_if ifc1();

    led_pattern_ctrl #(.N_LEDS(4), .STEP_BITS(3)) dut0 (
        .clk_50M(clk_50M), .rst(rst), .rx(ifc0), .leds(leds0), .mode(mode0)
    );
    led_pattern_ctrl #(.N_LEDS(1), .STEP_BITS(2)) dut1 (
        .clk_50M(clk_50M), .rst(rst), .rx(ifc1), .leds(leds1), .mode(mode1)
    );

    always #10 clk_50M = ~clk_50M;
    always @(posedge clk_50M) cyc <= cyc + 1;

    always @(negedge clk_50M) begin
        logic [3:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at <= cyc || flush) begin
                if (sb[i].which == 0) act = (sb[i].kind == 0) ? leds0 : {2'b00, mode0};
                else                  act = (sb[i].kind == 0) ? {3'b000, leds1} : {2'b00, mode1};
                tests++;
                if (sb[i].at != cyc) begin
                    fails++;
                    $display("FAIL %s: check for cycle %0d not taken (now %0d), expected %b",
                             sb[i].name, sb[i].at, cyc, sb[i].val);
                end else if (act !== sb[i].val) begin
                    fails++;
                    $display("FAIL %s @%0d: got %b, expected %b", sb[i].name, cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int at, input int which, input int kind,
                             input logic [3:0] val, input logic [63:0] name);
        exp_t e;
        e.at = at; e.which = which; e.kind = kind; e.val = val; e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk_50M);
    endtask

    task automatic send(input int t, input logic [7:0] bv);
        wait_to(t);
        ifc0.rx_valid = 1'b1;
        ifc0.rx_byte  = bv;
        @(negedge clk_50M);
        ifc0.rx_valid = 1'b0;
        ifc0.rx_byte  = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        expect_at(cyc + 1, 0, 0, 4'b0000, "rst_led");
        expect_at(cyc + 1, 0, 1, 4'd0,    "rst_mode");
        expect_at(cyc + 1, 1, 0, 4'd0,    "rst_led1");
        @(negedge clk_50M);
        rst  = 1'b0;
        base = cyc;
    endtask

    initial begin
        ifc0.rx_valid = 1'b0; ifc0.rx_byte = 8'h00;
        ifc1.rx_valid = 1'b0; ifc1.rx_byte = 8'h00;
        @(negedge clk_50M);

        // free-running bounce scan
        do_reset();
        for (int k = 0; k < 11; k++) expect_at(base + scan_at[k], 0, 0, scan_v[k], "scan");
        expect_at(base + 1, 0, 1, 4'd0, "scan_md");
        for (int k = 1; k <= 21; k += 4) expect_at(base + k, 1, 0, 4'b0001, "n1_scan");
        expect_at(base + 21, 1, 1, 4'd0, "n1_mode");
        wait_to(base + 75);

        // legacy direct, then scan restart
        do_reset();
        expect_at(base + 3,  0, 1, 4'd1,    "dir_md");
        expect_at(base + 4,  0, 0, 4'b0101, "dir_led");
        expect_at(base + 12, 0, 0, 4'b0101, "dir_led");
        expect_at(base + 20, 0, 0, 4'b0101, "dir_led");
        expect_at(base + 22, 0, 1, 4'd0,    "rescan");
        expect_at(base + 23, 0, 0, 4'b1000, "rescan");
        expect_at(base + 24, 0, 0, 4'b1000, "rescan");
        expect_at(base + 25, 0, 0, 4'b0100, "rescan");
        send(base + 2, 8'h05);
        send(base + 21, 8'h80);
        wait_to(base + 27);

        // prefixed load, blink, rotate
        do_reset();
        expect_at(base + 3,  0, 1, 4'd0,    "pfx_md");
        expect_at(base + 4,  0, 1, 4'd1,    "load_md");
        expect_at(base + 4,  0, 0, 4'b1000, "pfx_led");
        expect_at(base + 5,  0, 0, 4'b0011, "load");
        expect_at(base + 10, 0, 1, 4'd2,    "blink_md");
        expect_at(base + 11, 0, 0, 4'b0011, "blink");
        expect_at(base + 16, 0, 0, 4'b0011, "blink");
        expect_at(base + 17, 0, 0, 4'b0000, "blink");
        expect_at(base + 24, 0, 0, 4'b0000, "blink");
        expect_at(base + 25, 0, 0, 4'b0011, "blink");
        expect_at(base + 26, 0, 1, 4'd3,    "rot_md");
        expect_at(base + 27, 0, 0, 4'b0011, "rot");
        expect_at(base + 33, 0, 0, 4'b0110, "rot");
        expect_at(base + 41, 0, 0, 4'b1100, "rot");
        expect_at(base + 49, 0, 0, 4'b1001, "rot");
        expect_at(base + 57, 0, 0, 4'b0011, "rot");
        send(base + 2, 8'hC0);
        send(base + 3, 8'hF3);
        send(base + 9, 8'h82);
        send(base + 25, 8'h83);
        wait_to(base + 59);

        // brightness: duty 4/16, off, full
        do_reset();
        for (int j = 17; j <= 32; j++)
            expect_at(base + j, 0, 0, (((j - 1) % 16) < 4) ? 4'b1111 : 4'b0000, "pwm4");
        for (int j = 42; j <= 57; j++) expect_at(base + j, 0, 0, 4'b0000, "pwm0");
        for (int j = 60; j <= 75; j++) expect_at(base + j, 0, 0, 4'b1111, "pwm15");
        send(base + 2, 8'h0F);
        send(base + 4, 8'hA4);
        send(base + 40, 8'hA0);
        send(base + 58, 8'hAF);
        wait_to(base + 77);

        // reset while waiting for prefix data
        do_reset();
        expect_at(base + 3, 0, 1, 4'd2, "pre_md");
        send(base + 2, 8'h82);
        send(base + 3, 8'hC0);
        do_reset();
        expect_at(base + 3, 0, 1, 4'd3,    "abort_md");
        expect_at(base + 4, 0, 1, 4'd1,    "abort_md");
        expect_at(base + 5, 0, 0, 4'b1010, "abort_ld");
        send(base + 2, 8'h83);
        send(base + 3, 8'h0A);
        wait_to(base + 8);

        // load landing on a rotate tick
        do_reset();
        expect_at(base + 6,  0, 0, 4'b0001, "tk_rot");
        expect_at(base + 9,  0, 0, 4'b0010, "tk_rot");
        expect_at(base + 15, 0, 1, 4'd3,    "tk_md");
        expect_at(base + 16, 0, 1, 4'd1,    "tk_md");
        expect_at(base + 16, 0, 0, 4'b0010, "tk_led");
        expect_at(base + 17, 0, 0, 4'b1000, "tk_load");
        expect_at(base + 25, 0, 0, 4'b1000, "tk_load");
        send(base + 2, 8'hC0);
        send(base + 3, 8'h01);
        send(base + 4, 8'h83);
        send(base + 14, 8'hC0);
        send(base + 15, 8'h08);
        wait_to(base + 27);

        flush = 1'b1;
        @(negedge clk_50M);
        @(negedge clk_50M);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
